// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
//   REG_DATA_WIDTH  : register data width
//   RS_WIDTH        : register index width
//   REG_SIZE        : number of architectural registers
//   WB_STARVE_LIMIT : refused MDU cycles before starve_stall asserts
package regfile_wb_arbiter_pkg;

  localparam int REG_DATA_WIDTH  = 32;
  localparam int RS_WIDTH        = 5;
  localparam int REG_SIZE        = 32;
  localparam int WB_STARVE_LIMIT = 4;

  // Width of a counter that must hold the values 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the arbiter's requester, hazard-check and register-file signals.
//   master : drives the WB, MDU, issue and check inputs (pipeline / bench)
//   slave  : the arbiter; drives mdu_ready, hazard, rf_*, starve_stall, pending
// Handshake: the MDU result transfers in every cycle where mdu_valid and
// mdu_ready are both high; mdu_ready is combinational and never depends on
// mdu_valid, and the WB port has no backpressure at all.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_DATA_WIDTH,
  parameter int ADDR_W = RS_WIDTH,
  parameter int NREGS  = REG_SIZE
) ();

  logic              wb_we;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_rd;
  logic [DATA_W-1:0] mdu_data;
  logic              mdu_ready;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              chk_valid;
  logic [ADDR_W-1:0] chk_rs1;
  logic [ADDR_W-1:0] chk_rs2;
  logic [ADDR_W-1:0] chk_rd;
  logic              hazard;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;
  logic              starve_stall;
  logic [NREGS-1:0]  pending;

  modport master (
    output wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           iss_valid, iss_rd, chk_valid, chk_rs1, chk_rs2, chk_rd,
    input  mdu_ready, hazard, rf_we, rf_rd, rf_data, starve_stall, pending
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
           iss_valid, iss_rd, chk_valid, chk_rs1, chk_rs2, chk_rd,
    output mdu_ready, hazard, rf_we, rf_rd, rf_data, starve_stall, pending
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard for in-flight MDU ops.
//   clk, rst        : clock, synchronous active-high reset
//   set_en_i/rd_i   : mark a register as owned by a dispatched MDU op
//   clr_en_i/rd_i   : MDU result granted to the write port for that register
//   look*_rd_i      : three lookup ports (rs1, rs2, rd of the ID instruction)
//   hit_o           : per-port pending hit, with same-cycle grant bypass
//   pending_o       : the registered pending vector (bit 0 always 0)
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = RS_WIDTH,
  parameter int NREGS  = REG_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_rd_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_rd_i,
  input  logic [ADDR_W-1:0] look0_rd_i,
  input  logic [ADDR_W-1:0] look1_rd_i,
  input  logic [ADDR_W-1:0] look2_rd_i,
  output logic [2:0]        hit_o,
  output logic [NREGS-1:0]  pending_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Clear first, then set, so a register re-issued in its own grant cycle
  // stays owned by the new op.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_rd_i] = 1'b0;
    if (set_en_i && set_rd_i != '0) pending_d[set_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // A register being written this cycle is readable through the register
  // file's write-through, so its grant masks the hit.
  function automatic logic hit(input logic [ADDR_W-1:0] r);
    return (r != '0) && pending_q[r] && !(clr_en_i && clr_rd_i == r);
  endfunction

  assign hit_o     = {hit(look2_rd_i), hit(look1_rd_i), hit(look0_rd_i)};
  assign pending_o = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between pipeline WB
// (fixed priority, no backpressure) and the MDU (valid/ready), tracks MDU
// destination ownership for ID hazard detection, and raises starve_stall
// after STARVE_LIMIT consecutive refused MDU cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_wb_arbiter_if slave modport (all other signals)
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W       = REG_DATA_WIDTH,
  parameter int ADDR_W       = RS_WIDTH,
  parameter int NREGS        = REG_SIZE,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int              CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             wb_eff;
  logic             mdu_ready;
  logic             grant;
  logic [2:0]       hit;
  logic [NREGS-1:0] pending;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // A WB write to x0 is architecturally a no-op, so it never takes the port.
  assign wb_eff    = bus.wb_we && (bus.wb_rd != '0);
  assign mdu_ready = !rst && !wb_eff;
  assign grant     = bus.mdu_valid && mdu_ready;

  assign bus.mdu_ready = mdu_ready;

  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_rd   = '0;
    bus.rf_data = '0;
    if (!rst) begin
      if (wb_eff) begin
        bus.rf_we   = 1'b1;
        bus.rf_rd   = bus.wb_rd;
        bus.rf_data = bus.wb_data;
      end else if (grant && bus.mdu_rd != '0) begin
        bus.rf_we   = 1'b1;
        bus.rf_rd   = bus.mdu_rd;
        bus.rf_data = bus.mdu_data;
      end
    end
  end

  wb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (bus.iss_valid),
    .set_rd_i   (bus.iss_rd),
    .clr_en_i   (grant),
    .clr_rd_i   (bus.mdu_rd),
    .look0_rd_i (bus.chk_rs1),
    .look1_rd_i (bus.chk_rs2),
    .look2_rd_i (bus.chk_rd),
    .hit_o      (hit),
    .pending_o  (pending)
  );

  assign bus.hazard  = !rst && bus.chk_valid && (|hit);
  assign bus.pending = pending;

  // Counts consecutive refused MDU cycles; any grant or idle MDU restarts it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant || !bus.mdu_valid) wait_cnt_d = '0;
    else if (wait_cnt_q != LIMIT) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  assign bus.starve_stall = (wait_cnt_q == LIMIT);

  // Protocol checks on the requesters; hardware behaviour is defined anyway.
  a_wb_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(wb_eff && pending[bus.wb_rd]));
  a_iss_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(bus.iss_valid && bus.iss_rd != '0 && pending[bus.iss_rd] &&
      !(grant && bus.mdu_rd == bus.iss_rd)));
  a_grant_unowned: assert property (@(posedge clk) disable iff (rst)
    !(grant && bus.mdu_rd != '0 && !pending[bus.mdu_rd]));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rdy;
    logic        haz;
    logic        st;
    logic [31:0] pend;
  } exp_t;

  exp_t  exp_q[$];
  string lbl_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic cmp(input string l, input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", l, n, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  exp_t  m_e;
  string m_l;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      m_l = lbl_q.pop_front();
      cmp(m_l, "rf_we",        {31'd0, bus.rf_we},        {31'd0, m_e.we});
      cmp(m_l, "rf_rd",        {27'd0, bus.rf_rd},        {27'd0, m_e.rd});
      cmp(m_l, "rf_data",      bus.rf_data,               m_e.data);
      cmp(m_l, "mdu_ready",    {31'd0, bus.mdu_ready},    {31'd0, m_e.rdy});
      cmp(m_l, "hazard",       {31'd0, bus.hazard},       {31'd0, m_e.haz});
      cmp(m_l, "starve_stall", {31'd0, bus.starve_stall}, {31'd0, m_e.st});
      cmp(m_l, "pending",      bus.pending,               m_e.pend);
    end
  end

  task automatic idle();
    bus.wb_we     = 1'b0; bus.wb_rd  = '0; bus.wb_data  = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.chk_valid = 1'b0; bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.wb_we = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
  endtask

  task automatic mdu(input logic [4:0] rd, input logic [31:0] d);
    bus.mdu_valid = 1'b1; bus.mdu_rd = rd; bus.mdu_data = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    bus.iss_valid = 1'b1; bus.iss_rd = rd;
  endtask

  task automatic chk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.chk_valid = 1'b1; bus.chk_rs1 = rs1; bus.chk_rs2 = rs2; bus.chk_rd = rd;
  endtask

  // Push the expected outputs for the cycle just driven, then advance.
  task automatic step(input string lbl, input logic we, input logic [4:0] rd,
                      input logic [31:0] data, input logic rdy, input logic haz,
                      input logic st, input logic [31:0] pend);
    exp_t e;
    e = '{we: we, rd: rd, data: data, rdy: rdy, haz: haz, st: st, pend: pend};
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    wb(5'd3, 32'hAAAA_0000); mdu(5'd7, 32'h1); iss(5'd5); chk(5'd5, 5'd0, 5'd0);
    @(posedge clk); #1;
    step("rst0", 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    idle(); wb(5'd3, 32'h1111_2222);
    step("release", 1, 3, 32'h1111_2222, 0, 0, 0, 0);

    // Collision: WB wins, MDU lands the next cycle.
    idle(); iss(5'd7);
    step("iss7", 0, 0, 0, 1, 0, 0, 0);
    idle(); wb(5'd3, 32'hAAAA_5555); mdu(5'd7, 32'h1234_5678);
    step("coll_wb", 1, 3, 32'hAAAA_5555, 0, 0, 0, 32'h80);
    bus.wb_we = 1'b0;
    step("coll_mdu", 1, 7, 32'h1234_5678, 1, 0, 0, 32'h80);

    // RAW on rs2 with grant bypass.
    idle(); iss(5'd5);
    step("iss5", 0, 0, 0, 1, 0, 0, 0);
    idle(); chk(5'd1, 5'd5, 5'd6);
    step("raw", 0, 0, 0, 1, 1, 0, 32'h20);
    mdu(5'd5, 32'h55);
    step("raw_bypass", 1, 5, 32'h55, 1, 0, 0, 32'h20);
    idle(); chk(5'd1, 5'd5, 5'd6);
    step("raw_clr", 0, 0, 0, 1, 0, 0, 0);

    // Set wins over clear; WAW via chk_rd.
    idle(); iss(5'd9);
    step("iss9", 0, 0, 0, 1, 0, 0, 0);
    idle(); mdu(5'd9, 32'h99); iss(5'd9); chk(5'd0, 5'd0, 5'd9);
    step("setwin", 1, 9, 32'h99, 1, 0, 0, 32'h200);
    idle(); chk(5'd0, 5'd0, 5'd9);
    step("waw", 0, 0, 0, 1, 1, 0, 32'h200);
    idle(); mdu(5'd9, 32'h9999);
    step("clr9", 1, 9, 32'h9999, 1, 0, 0, 32'h200);

    // x0 cases.
    idle(); iss(5'd4);
    step("iss4", 0, 0, 0, 1, 0, 0, 0);
    idle(); wb(5'd0, 32'hDEAD); mdu(5'd4, 32'h44); iss(5'd0); chk(5'd0, 5'd0, 5'd0);
    step("x0_wb", 1, 4, 32'h44, 1, 0, 0, 32'h10);
    idle(); mdu(5'd0, 32'h77); chk(5'd0, 5'd0, 5'd0);
    step("x0_mdu", 0, 0, 0, 1, 0, 0, 0);

    // Starvation: stall from the 5th refused cycle, saturating.
    idle(); iss(5'd6);
    step("iss6", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      idle(); wb(5'd2, 32'h2000 + i); mdu(5'd6, 32'h66);
      step("starve", 1, 2, 32'h2000 + i, 0, 0, (i >= 4), 32'h40);
    end
    bus.wb_we = 1'b0;
    step("starve_grant", 1, 6, 32'h66, 1, 0, 1, 32'h40);
    idle();
    step("starve_clr", 0, 0, 0, 1, 0, 0, 0);

    // Idle MDU restarts the count.
    idle(); iss(5'd8);
    step("iss8", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); wb(5'd2, 32'h3000 + i); mdu(5'd8, 32'h88);
      step("zero_a", 1, 2, 32'h3000 + i, 0, 0, 0, 32'h100);
    end
    idle(); wb(5'd2, 32'h3100);
    step("zero_idle", 1, 2, 32'h3100, 0, 0, 0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      idle(); wb(5'd2, 32'h3200 + i); mdu(5'd8, 32'h88);
      step("zero_b", 1, 2, 32'h3200 + i, 0, 0, 0, 32'h100);
    end
    idle(); mdu(5'd8, 32'h88);
    step("zero_grant", 1, 8, 32'h88, 1, 0, 0, 32'h100);
    idle();
    step("zero_clr", 0, 0, 0, 1, 0, 0, 0);

    // Reset in the middle of an outstanding op.
    idle(); iss(5'd10);
    step("iss10", 0, 0, 0, 1, 0, 0, 0);
    idle(); wb(5'd2, 32'h4000); mdu(5'd10, 32'hAA); chk(5'd0, 5'd0, 5'd10);
    step("pre_rst", 1, 2, 32'h4000, 0, 1, 0, 32'h400);
    rst = 1'b1;
    step("mid_rst", 0, 0, 0, 0, 0, 0, 32'h400);
    rst = 1'b0;
    idle(); chk(5'd0, 5'd0, 5'd10);
    step("post_rst", 0, 0, 0, 1, 0, 0, 0);

    idle();
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    cmp("end", "queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
